tft_lcd_timing_ctrl: RTL
========================

Name: tft_lcd_timing_ctrl

Overview:
- Generates parallel RGB TFT LCD timing (PCLK, DISP, HSYNC, VSYNC, DE, RGB) from a 24-bit pixel stream.
- Drives the TFT_* pins of dut_top that feed the board's TFT LCD model, which samples on the falling edge of TFT_PCLK.
- Upstream is a frame fetcher on the AXI4 master using a valid/ready pixel stream.
- Handles panel power sequencing on enable/disable and flags underrun.

Parameters:
- C_PCLK_DIV, 4: CLK cycles per pixel; even, >=2.
- C_H_ACTIVE, 480: active pixels per line.
- C_H_FRONT, 2: horizontal front porch (pixels).
- C_H_SYNC, 41: HSYNC width (pixels).
- C_H_BACK, 2: horizontal back porch (pixels).
- C_V_ACTIVE, 272: active lines per frame.
- C_V_FRONT, 2: vertical front porch (lines).
- C_V_SYNC, 10: VSYNC width (lines).
- C_V_BACK, 2: vertical back porch (lines).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- EN  in  1  display enable (level).
- PIX_VALID  in  1  pixel stream valid.
- PIX_DATA  in  24  pixel {R,G,B}.
- PIX_READY  out  1  pixel accepted this cycle when PIX_VALID is also high.
- FRAME_START  out  1  one-CLK pulse at start of each enabled frame.
- UNDERRUN  out  1  sticky underrun flag.
- UNDERRUN_CLR  in  1  clears UNDERRUN.
- TFT_PCLK  out  1  pixel clock.
- TFT_DISP  out  1  panel on.
- TFT_HSYNC  out  1  active-low.
- TFT_VSYNC  out  1  active-low.
- TFT_DE  out  1  data enable.
- TFT_RGB  out  24  pixel data.

Behaviour:
- Clock/reset: one clock (CLK); reset nRST is asynchronous, active-low.
- Reset values: TFT_PCLK=0, TFT_DISP=0, TFT_HSYNC=1, TFT_VSYNC=1, TFT_DE=0, TFT_RGB=0, PIX_READY=0, FRAME_START=0, UNDERRUN=0. All counters=0, state=OFF.
- Divider:
  - div counter runs 0..C_PCLK_DIV-1 continuously after reset.
  - TFT_PCLK (registered) is 1 for div in [0, C_PCLK_DIV/2), else 0.
  - A pixel tick is the CLK cycle with div==C_PCLK_DIV-1.
  - All TFT_* data outputs are registered on the tick, so they change with the PCLK rising edge and are stable at the falling edge.
- Counters: hcnt 0..H_TOTAL-1 advances each tick. On wrap, vcnt 0..V_TOTAL-1 advances. Both wrap to 0.
- Region order: active, front, sync, back, for both h and v.
- Timing outputs:
  - HSYNC=0 while hcnt is in the h sync region; VSYNC=0 while vcnt is in the v sync region. Counters and syncs run in every state except OFF.
  - TFT_DE = state==RUN && h active && v active.
- PIX_READY = tick && state==RUN && next pixel position is active; combinational from registers.
  - Accepted pixel: TFT_RGB<=PIX_DATA.
  - At an active tick with PIX_VALID=0: TFT_RGB<=0, DE still 1, UNDERRUN<=1.
  - Outside DE: TFT_RGB=0.
- UNDERRUN: UNDERRUN_CLR wins over a simultaneous set.
- FRAME_START pulses on the tick where hcnt=vcnt=0 in RUN, one cycle before the first READY.
- State machine:
  - OFF: DISP=0, counters held 0, syncs high. EN=1 -> WAKE.
  - WAKE: DISP=1, counters run, DE=0 for one full frame. At vcnt/hcnt wrap to 0: EN=1 -> RUN; EN=0 -> OFF.
  - RUN: normal output. EN=0 -> DRAIN (current frame continues).
  - DRAIN: DE continues until end of current frame; READY is still asserted. At frame wrap -> SLEEP.
  - SLEEP: DISP=1, DE=0 for one frame, then OFF and DISP=0. EN=1 during SLEEP is ignored until OFF.
- EN toggling mid-frame never truncates an active frame.
- Reset mid-frame returns immediately to reset values.

Optional Feature:
- Macro: TFT_TEST_PATTERN_EN.
- Defined:
  - Adds input TEST_MODE (1 bit).
  - When TEST_MODE=1 in RUN: PIX_READY=0, UNDERRUN is not set, and TFT_RGB shows 8 vertical colour bars selected by hcnt*8/C_H_ACTIVE.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black (0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000).
  - TEST_MODE is sampled at FRAME_START only.
- Undefined: no TEST_MODE port, no pattern logic.

Test Plan:
- Bench parameters: DIV=2, H=8/1/2/1 (total 12), V=4/1/1/1 (total 7).
- Reset held, then released with EN=0 -> DISP=0, HSYNC=VSYNC=1, DE=0, RGB=0; TFT_PCLK toggles every CLK.
- EN=1, PIX_VALID=1 with incrementing data 1,2,3… -> one WAKE frame (84 ticks, DE=0), then FRAME_START; DE high 8 ticks per line × 4 lines; RGB=1..32 in order; UNDERRUN=0.
- PIX_VALID=0 for pixel index 5 of line 0 -> RGB=0 at that tick, DE=1, UNDERRUN=1 until UNDERRUN_CLR; CLR and a new underrun in the same cycle -> UNDERRUN=0.
- Check sync placement -> HSYNC low exactly at hcnt 9–10; VSYNC low exactly at vcnt 5.
- EN dropped at line 1 pixel 3 -> frame finishes with 32 pixels, one SLEEP frame with DISP=1 and DE=0, then DISP=0; EN=1 during SLEEP has no effect until OFF.
- nRST asserted mid-line during DE -> all outputs return to reset values asynchronously; after release with EN=1, a full WAKE frame precedes RUN.

Source files
------------

// File: rtl/tft_lcd_timing_ctrl_if.sv
// rtl/tft_lcd_timing_ctrl_if.sv - valid/ready pixel stream between frame fetcher and TFT timing controller
interface tft_lcd_timing_ctrl_if;
  logic        PIX_VALID;
  logic [23:0] PIX_DATA;
  logic        PIX_READY;

  modport master (
    output PIX_VALID,
    output PIX_DATA,
    input  PIX_READY
  );

  modport slave (
    input  PIX_VALID,
    input  PIX_DATA,
    output PIX_READY
  );
endinterface

// File: rtl/tft_lcd_timing_ctrl.sv
// rtl/tft_lcd_timing_ctrl.sv - parallel RGB TFT timing generator with panel power sequencing
// Optional colour-bar test pattern is built when TFT_TEST_PATTERN_EN is defined.
module tft_lcd_timing_ctrl #(
  parameter int C_PCLK_DIV = 4,
  parameter int C_H_ACTIVE = 480,
  parameter int C_H_FRONT  = 2,
  parameter int C_H_SYNC   = 41,
  parameter int C_H_BACK   = 2,
  parameter int C_V_ACTIVE = 272,
  parameter int C_V_FRONT  = 2,
  parameter int C_V_SYNC   = 10,
  parameter int C_V_BACK   = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 EN,
  tft_lcd_timing_ctrl_if.slave pix,
  output logic                 FRAME_START,
  output logic                 UNDERRUN,
  input  logic                 UNDERRUN_CLR,
`ifdef TFT_TEST_PATTERN_EN
  input  logic                 TEST_MODE,
`endif
  output logic                 TFT_PCLK,
  output logic                 TFT_DISP,
  output logic                 TFT_HSYNC,
  output logic                 TFT_VSYNC,
  output logic                 TFT_DE,
  output logic [23:0]          TFT_RGB
);

  localparam int H_TOTAL = C_H_ACTIVE + C_H_FRONT + C_H_SYNC + C_H_BACK;
  localparam int V_TOTAL = C_V_ACTIVE + C_V_FRONT + C_V_SYNC + C_V_BACK;
  localparam int DW      = $clog2(C_PCLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST   = DW'(C_PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(C_PCLK_DIV / 2);
  localparam logic [HW-1:0] H_ACT_END  = HW'(C_H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(C_H_ACTIVE + C_H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(C_H_ACTIVE + C_H_FRONT + C_H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(C_V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(C_V_ACTIVE + C_V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(C_V_ACTIVE + C_V_FRONT + C_V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          pos_active;
  logic          h_sync;
  logic          v_sync;
  logic          streaming;
  logic          pattern_on;
  logic          underrun_set;
  logic [23:0]   bar_rgb;
  logic [23:0]   rgb_nxt;

  // hcnt/vcnt always name the position that the next tick will put on the pins
  always_comb begin
    div_nxt    = (div == DIV_LAST) ? '0 : div + 1'b1;
    tick       = (div == DIV_LAST);
    h_last     = (hcnt == H_LAST);
    v_last     = (vcnt == V_LAST);
    frame_wrap = tick && h_last && v_last;
    pos_active = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    h_sync     = (state != ST_OFF) && (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
    v_sync     = (state != ST_OFF) && (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
    streaming  = (state == ST_RUN) || (state == ST_DRAIN);
  end

`ifdef TFT_TEST_PATTERN_EN
  logic       pattern_mode;
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'((32'(hcnt) * 8) / C_H_ACTIVE);
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // TEST_MODE only takes effect at a frame boundary so a frame is never mixed
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pattern_mode <= 1'b0;
    end else if (frame_wrap && (state_nxt == ST_RUN)) begin
      pattern_mode <= TEST_MODE;
    end
  end

  assign pattern_on = pattern_mode && streaming;
`else
  assign pattern_on = 1'b0;
  assign bar_rgb    = '0;
`endif

  assign pix.PIX_READY = tick && streaming && pos_active && !pattern_on;
  assign underrun_set  = tick && streaming && pos_active && !pattern_on && !pix.PIX_VALID;

  always_comb begin
    rgb_nxt = '0;
    if (streaming && pos_active) begin
      if (pattern_on) begin
        rgb_nxt = bar_rgb;
      end else if (pix.PIX_VALID) begin
        rgb_nxt = pix.PIX_DATA;
      end
    end
  end

  // RUN leaves only through DRAIN or a frame boundary, so an active frame is never cut short
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (EN) state_nxt = ST_WAKE;
      ST_WAKE:  if (frame_wrap) state_nxt = EN ? ST_RUN : ST_OFF;
      ST_RUN:   if (!EN) state_nxt = frame_wrap ? ST_SLEEP : ST_DRAIN;
      ST_DRAIN: if (frame_wrap) state_nxt = ST_SLEEP;
      ST_SLEEP: if (frame_wrap) state_nxt = ST_OFF;
      default:  state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_OFF;
      div      <= '0;
      TFT_PCLK <= 1'b0;
      TFT_DISP <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
    end else begin
      state    <= state_nxt;
      div      <= div_nxt;
      TFT_PCLK <= (div_nxt < DIV_HALF);
      TFT_DISP <= (state_nxt != ST_OFF);
      if (state == ST_OFF) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (tick) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      TFT_HSYNC   <= 1'b1;
      TFT_VSYNC   <= 1'b1;
      TFT_DE      <= 1'b0;
      TFT_RGB     <= '0;
      FRAME_START <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      FRAME_START <= frame_wrap && (state_nxt == ST_RUN);
      if (UNDERRUN_CLR) begin
        UNDERRUN <= 1'b0;
      end else if (underrun_set) begin
        UNDERRUN <= 1'b1;
      end
      if (tick) begin
        TFT_HSYNC <= !h_sync;
        TFT_VSYNC <= !v_sync;
        TFT_DE    <= streaming && pos_active;
        TFT_RGB   <= rgb_nxt;
      end
    end
  end

endmodule
